// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer.
//   - state_t     : sequencer states (IDLE, RUN, DONE)
//   - BYTE_W      : width of one datapath byte fed to the 8-bit addsub unit
//   - IDX_W_DEF   : byte-index width for the default 4-byte configuration
//   - idx_width() : byte-index width for any operand size (at least 1 bit)
//   - ovf_flag()  : signed-overflow rule for add and subtract
package addsub_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 4;
    localparam int IDX_W_DEF  = $clog2(NBYTES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the byte index; a 2-byte operand still needs one index bit.
    function automatic int idx_width(input int nbytes);
        if (nbytes > 2) begin
            idx_width = $clog2(nbytes);
        end else begin
            idx_width = 1;
        end
    endfunction

    // Signed overflow from the operand and result sign bits.
    // Add overflows when like-signed operands give a differently signed result;
    // subtract overflows when unlike-signed operands give a result whose sign
    // differs from the minuend.
    function automatic logic ovf_flag(input logic sub,
                                      input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
        if (sub) begin
            ovf_flag = (a_msb != b_msb) & (r_msb != a_msb);
        end else begin
            ovf_flag = (a_msb == b_msb) & (r_msb != a_msb);
        end
    endfunction

endpackage

// File: rtl/addsub_seq.sv
// Multi-byte add/subtract sequencer around an external 8-bit addsub unit.
// Latches two NBYTES-wide operands on an accepted start, streams them to the
// addsub unit one byte per cycle (LSB first) with carry/borrow chaining, and
// assembles the wide result plus cout/zero/neg/ovf flags.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, sub_i        : request (accepted only in IDLE) and add/sub select
//   a_i, b_i            : operands, sampled on the accepted start
//   busy, done          : busy during the byte loop, one-cycle done pulse
//   res_o, cout_o,
//   zero_o, neg_o, ovf_o: result and flags, held until the next accept
//   as_x, as_y, as_sub,
//   as_cin, as_carry    : drive to the addsub unit (all zero outside RUN)
//   as_sum, as_cout     : combinational result from the addsub unit
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sub_i,
    input  logic [NBYTES*BYTE_W-1:0]   a_i,
    input  logic [NBYTES*BYTE_W-1:0]   b_i,
    output logic                       busy,
    output logic                       done,
    output logic [NBYTES*BYTE_W-1:0]   res_o,
    output logic                       cout_o,
    output logic                       zero_o,
    output logic                       neg_o,
    output logic                       ovf_o,
    output logic [BYTE_W-1:0]          as_x,
    output logic [BYTE_W-1:0]          as_y,
    output logic                       as_sub,
    output logic                       as_cin,
    output logic                       as_carry,
    input  logic [BYTE_W-1:0]          as_sum,
    input  logic                       as_cout
);

    localparam int BW     = BYTE_W;
    localparam int W      = NBYTES * BW;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam int NSLOTS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic                sub_r;
    logic [W-1:0]        res_r;
    logic [W-1:0]        res_next_s;
    logic                carry_r;
    logic                busy_r;
    logic                done_r;
    logic                cout_r;
    logic                zero_r;
    logic                neg_r;
    logic                ovf_r;
    logic                last_byte_s;

    // Byte views of the latched operands; slots beyond NBYTES read as zero so
    // the index can never select an undefined byte.
    logic [BW-1:0]       a_bytes_s [NSLOTS];
    logic [BW-1:0]       b_bytes_s [NSLOTS];

    for (genvar g = 0; g < NSLOTS; g++) begin : g_bytes
        if (g < NBYTES) begin : g_real
            assign a_bytes_s[g] = a_r[g*BW +: BW];
            assign b_bytes_s[g] = b_r[g*BW +: BW];
        end else begin : g_pad
            assign a_bytes_s[g] = 8'h00;
            assign b_bytes_s[g] = 8'h00;
        end
    end

    assign last_byte_s = (idx_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so a request during
    // RUN or coincident with done is dropped.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_byte_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Result with the byte currently coming back from addsub merged in; the
    // flags are taken from this so they are valid in the DONE cycle.
    always_comb begin
        res_next_s = res_r;
        for (int i = 0; i < NBYTES; i++) begin
            res_next_s[i*BW +: BW] = (idx_r == IDX_W'(i)) ? as_sum : res_r[i*BW +: BW];
        end
    end

    // Drive to the addsub unit: only active in RUN. Byte 0 runs with the
    // carry chain disabled; later bytes chain the previous carry/borrow.
    always_comb begin
        as_x     = 8'h00;
        as_y     = 8'h00;
        as_sub   = 1'b0;
        as_cin   = 1'b0;
        as_carry = 1'b0;
        if (state_r == RUN) begin
            as_x     = a_bytes_s[idx_r];
            as_y     = b_bytes_s[idx_r];
            as_sub   = sub_r;
            as_carry = (idx_r != IDX_ZERO);
            as_cin   = (idx_r != IDX_ZERO) & carry_r;
        end else begin
            as_x     = 8'h00;
            as_y     = 8'h00;
            as_sub   = 1'b0;
            as_cin   = 1'b0;
            as_carry = 1'b0;
        end
    end

    // Operand latch, byte loop and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sub_r   <= 1'b0;
            idx_r   <= IDX_ZERO;
            res_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a_i;
                        b_r     <= b_i;
                        sub_r   <= sub_i;
                        idx_r   <= IDX_ZERO;
                        res_r   <= {W{1'b0}};
                        carry_r <= 1'b0;
                        busy_r  <= 1'b1;
                        cout_r  <= 1'b0;
                        zero_r  <= 1'b0;
                        neg_r   <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    carry_r <= as_cout;
                    idx_r   <= idx_r + IDX_ONE;
                    if (last_byte_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        cout_r <= as_cout;
                        zero_r <= ~|res_next_s;
                        neg_r  <= res_next_s[W-1];
                        ovf_r  <= ovf_flag(sub_r, a_r[W-1], b_r[W-1], res_next_s[W-1]);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign res_o  = res_r;
    assign cout_o = cout_r;
    assign zero_o = zero_r;
    assign neg_o  = neg_r;
    assign ovf_o  = ovf_r;

endmodule
